pe_mac_acc: RTL and testbench

- Upstream stage of the PE ReLU: a streaming signed multiply-accumulate.
- Consumes operand pairs over a valid/ready handshake and sums one window of products; the window is delimited by in_last.
- Emits one saturated W-bit signed partial sum per window. That sum feeds the ReLU stage directly.
- Also reports a sticky overflow flag and the term count.

---
 rtl/pe_pkg.sv | 32 +++
 rtl/pe_sat_add.sv | 33 +++
 rtl/pe_mac_acc.sv | 132 +++++++++++++
 tb/tb_pe_mac_acc.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants, state encoding and saturation helper for the PE datapath stages.
package pe_pkg;

    localparam int PE_DW    = 8;
    localparam int PE_W     = 24;
    localparam int PE_CNT_W = 10;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } pe_state_e;

    typedef struct packed {
        logic            clamp;
        logic [PE_W-1:0] val;
    } sat_res_t;

    // Overflow of a W+1-bit value into W bits shows up as disagreeing top two bits.
    function automatic sat_res_t sat_clamp(input logic [PE_W:0] v);
        sat_res_t r;
        r.clamp = v[PE_W] ^ v[PE_W-1];
        if (!r.clamp) begin
            r.val = v[PE_W-1:0];
        end else if (v[PE_W]) begin
            r.val = {1'b1, {(PE_W-1){1'b0}}};
        end else begin
            r.val = {1'b0, {(PE_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational W+1-bit signed add followed by a clamp to the signed W-bit range.
module pe_sat_add
    import pe_pkg::*;
#(
    parameter int W = PE_W
) (
    input  logic [W:0]   a_i,
    input  logic [W:0]   b_i,
    output logic [W-1:0] sum_o,
    output logic         sat_o
);

    logic [W:0] raw;
    assign raw = a_i + b_i;

    generate
        if (W == PE_W) begin : g_pkg
            sat_res_t res;
            assign res   = sat_clamp(raw);
            assign sum_o = res.val;
            assign sat_o = res.clamp;
        end else begin : g_gen
            always_comb begin
                sat_o = raw[W] ^ raw[W-1];
                sum_o = raw[W-1:0];
                if (sat_o) begin
                    sum_o = raw[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pe_mac_acc.sv
// Streaming signed multiply-accumulate: sums one in_last-delimited window of
// products and emits a saturated partial sum, sticky clamp flag and term count.
module pe_mac_acc
    import pe_pkg::*;
#(
    parameter int DW    = PE_DW,
    parameter int W     = PE_W,
    parameter int CNT_W = PE_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [W-1:0]  out_data,
    output logic                 out_sat,
    output logic [CNT_W-1:0]     out_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pe_state_e        state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic                   accept;
    logic                   first;
    logic signed [2*DW-1:0] a_ext, b_ext, prod;
    logic [W:0]             prod_ext, acc_ext;
    logic [W-1:0]           sum;
    logic                   sum_clamp;
    logic                   sat_nxt;
    logic [CNT_W-1:0]       cnt_nxt;

    assign in_ready = rst_n && !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    // clr turns a coincident beat into the first term of a fresh window.
    assign first    = clr || (state_q == IDLE);

    assign a_ext    = {{DW{in_a[DW-1]}}, in_a};
    assign b_ext    = {{DW{in_b[DW-1]}}, in_b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(W+1-2*DW){prod[2*DW-1]}}, prod};
    assign acc_ext  = first ? '0 : {acc_q[W-1], acc_q};

    pe_sat_add #(.W(W)) u_sat_add (
        .a_i   (acc_ext),
        .b_i   (prod_ext),
        .sum_o (sum),
        .sat_o (sum_clamp)
    );

    assign sat_nxt = sum_clamp || (!first && sat_q);
    assign cnt_nxt = first ? CNT_W'(1) :
                     (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_cnt_d   = out_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
        end
        if (accept) begin
            if (in_last) begin
                state_d     = IDLE;
                acc_d       = '0;
                sat_d       = 1'b0;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = sum;
                out_sat_d   = sat_nxt;
                out_cnt_d   = cnt_nxt;
            end else begin
                state_d = ACC;
                acc_d   = sum;
                sat_d   = sat_nxt;
                cnt_d   = cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_pe_mac_acc.sv
// Bench for pe_mac_acc: directed scenarios plus random windows against an
// arithmetic window model (running clamped sum, sticky flag, saturating count).
module tb_pe_mac_acc;

    localparam int     DW    = 8;
    localparam int     W     = 24;
    localparam int     CNT_W = 10;
    localparam longint SMAX  = 64'sd8388607;
    localparam longint SMIN  = -64'sd8388608;
    localparam int     CMAX  = 1023;

    logic                 clk = 1'b0;
    logic                 rst_n, clr, in_valid, in_ready, in_last;
    logic                 out_valid, out_ready, out_sat;
    logic signed [DW-1:0] in_a, in_b;
    logic signed [W-1:0]  out_data;
    logic [CNT_W-1:0]     out_cnt;

    always #5 clk = ~clk;

    pe_mac_acc #(.DW(DW), .W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_cnt   (out_cnt)
    );

    typedef struct {
        longint d;
        bit     s;
        int     c;
    } res_t;

    res_t   exp_q[$];
    res_t   got_q[$];
    int     checks = 0;
    int     passes = 0;
    bit     rand_ready = 1'b0;

    longint m_acc = 0;
    bit     m_sat = 1'b0;
    int     m_cnt = 0;
    bit     m_first = 1'b1;

    // Results are collected mid-cycle, after the bench has driven its inputs.
    always begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
            got_q.push_back('{longint'(out_data), out_sat, int'(out_cnt)});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1);
    end

    function automatic void model_clear();
        m_first = 1'b1;
        m_acc   = 0;
        m_sat   = 1'b0;
        m_cnt   = 0;
    endfunction

    function automatic void model_beat(input longint a, input longint b, input bit last);
        longint s;
        bit     c;
        s = (m_first ? 0 : m_acc) + a * b;
        c = 1'b0;
        if (s > SMAX) begin s = SMAX; c = 1'b1; end
        if (s < SMIN) begin s = SMIN; c = 1'b1; end
        m_sat = (m_first ? 1'b0 : m_sat) | c;
        m_cnt = m_first ? 1 : ((m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1);
        m_acc = s;
        if (last) begin
            exp_q.push_back('{s, m_sat, m_cnt});
            model_clear();
        end else begin
            m_first = 1'b0;
        end
    endfunction

    task automatic beat(input int a, input int b, input bit last, input bit c = 1'b0);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_a     = a[DW-1:0];
        in_b     = b[DW-1:0];
        in_last  = last;
        clr      = c;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            acc = in_ready;
            if (c && k == 0) model_clear();
            if (acc) model_beat(a, b, last);
            @(negedge clk);
            clr = 1'b0;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            done = acc;
        end
        if (!done) begin
            checks++;
            $display("FAIL beat_accept: in_ready stayed 0, required 1 within 200 cycles");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic check_results(input string name);
        res_t g, e;
        out_ready = 1'b1;
        for (int k = 0; k < 300 && got_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL %s_count: got %0d results, required %0d", name, got_q.size(), exp_q.size());
        else
            passes++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g.d != e.d || g.s != e.s || g.c != e.c)
                $display("FAIL %s_result: got data=%0d sat=%0d cnt=%0d, required data=%0d sat=%0d cnt=%0d",
                         name, g.d, g.s, g.c, e.d, e.s, e.c);
            else
                passes++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", out_valid); else passes++;
        checks++; if (out_data !== '0) $display("FAIL rst_data: got %0d, required 0", out_data); else passes++;
        checks++; if (out_sat !== 1'b0) $display("FAIL rst_sat: got %b, required 0", out_sat); else passes++;
        checks++; if (out_cnt !== '0) $display("FAIL rst_cnt: got %0d, required 0", out_cnt); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b, required 0", in_ready); else passes++;
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        beat(2, 3, 1'b0);
        beat(-4, 5, 1'b0);
        beat(7, 1, 1'b1);
        checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b, required 1", out_valid); else passes++;
        checks++; if (longint'(out_data) != -7) $display("FAIL basic_data: got %0d, required -7", out_data); else passes++;
        checks++; if (out_sat !== 1'b0 || out_cnt != 3)
            $display("FAIL basic_flags: got sat=%b cnt=%0d, required sat=0 cnt=3", out_sat, out_cnt); else passes++;
        idle(1);
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_pulse: got valid %b, required 0", out_valid); else passes++;
        check_results("basic");
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        for (int i = 0; i < 1100; i++) beat(127, 127, i == 1099);
        check_results("ovf_pos");
        checks++; if (longint'(out_data) != SMAX || out_sat !== 1'b1 || out_cnt != 1023)
            $display("FAIL ovf_pos_hold: got data=%0d sat=%b cnt=%0d, required 8388607 1 1023", out_data, out_sat, out_cnt);
        else passes++;
        for (int i = 0; i < 1100; i++) beat(-128, 127, i == 1099);
        check_results("ovf_neg");
        checks++; if (longint'(out_data) != SMIN || out_sat !== 1'b1 || out_cnt != 1023)
            $display("FAIL ovf_neg_hold: got data=%0d sat=%b cnt=%0d, required -8388608 1 1023", out_data, out_sat, out_cnt);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic signed [W-1:0] held;
        int a, b;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, i == 3);
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
        in_valid = 1'b1; in_a = a[DW-1:0]; in_b = b[DW-1:0]; in_last = 1'b0;
        held = out_data;
        checks++; if (longint'(held) != exp_q[$].d)
            $display("FAIL bp_result: got %0d, required %0d", held, exp_q[$].d); else passes++;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready: got %b, required 0", in_ready); else passes++;
            @(negedge clk);
            checks++; if (out_data !== held || out_valid !== 1'b1)
                $display("FAIL bp_hold: got data=%0d valid=%b, required %0d 1", out_data, out_valid, held); else passes++;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b, required 1", in_ready); else passes++;
        if (in_ready === 1'b1) model_beat(a, b, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        beat(int'($urandom_range(0, 255)) - 128, 17, 1'b0);
        beat(-3, int'($urandom_range(0, 255)) - 128, 1'b1);
        check_results("bp");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_a = DW'(i); in_b = 8'sd1; in_last = 1'b1;
            #1;
            if (in_ready === 1'b1) model_beat(i, 1, 1'b1);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || longint'(out_data) != i)
                $display("FAIL b2b_seq: got valid=%b data=%0d, required 1 %0d", out_valid, out_data, i); else passes++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        check_results("b2b");
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        beat(10, 10, 1'b0);
        beat(10, 10, 1'b0);
        beat(3, 3, 1'b1, 1'b1);
        checks++; if (longint'(out_data) != 9 || out_cnt != 1 || out_sat !== 1'b0)
            $display("FAIL clr_result: got data=%0d cnt=%0d sat=%b, required 9 1 0", out_data, out_cnt, out_sat); else passes++;
        check_results("clr");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        beat(5, 5, 1'b0);
        beat(5, 5, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0 || out_cnt !== '0 || in_ready !== 1'b0)
            $display("FAIL rstmid_outputs: got valid=%b data=%0d sat=%b cnt=%0d ready=%b, required all 0",
                     out_valid, out_data, out_sat, out_cnt, in_ready); else passes++;
        rst_n = 1'b1;
        model_clear();
        beat(1, 1, 1'b1);
        checks++; if (longint'(out_data) != 1 || out_cnt != 1)
            $display("FAIL rstmid_result: got data=%0d cnt=%0d, required 1 1", out_data, out_cnt); else passes++;
        check_results("rstmid");
    endtask

    task automatic test_random();
        int len;
        rand_ready = 1'b1;
        for (int w = 0; w < 60; w++) begin
            len = int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++)
                beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     j == len - 1, ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_ready = 1'b0;
        check_results("random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_clr();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
